// File: rtl/fifo_regfile.sv
// Storage array for fwft_fifo: one synchronous write port, one combinational read port.
// Contents are deliberately left unreset; validity is tracked by the owner's pointers.
module fifo_regfile #(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [W-1:0]  i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [W-1:0]  o_rdata
);

  logic [W-1:0] r_mem [DEPTH];

  // Only the addressed entry changes on a write.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/fwft_fifo.sv
// First-word-fall-through FIFO with registered-state handshakes, flush and almost_full.
// Pointers carry one extra wrap bit so full/empty arithmetic needs no special cases.
module fwft_fifo #(
  parameter int W         = 8,
  parameter int DEPTH     = 4,
  parameter int AF_THRESH = DEPTH - 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   in_valid,
  input  logic [W-1:0]           in_data,
  output logic                   in_ready,
  output logic                   out_valid,
  output logic [W-1:0]           out_data,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] count,
  output logic                   almost_full
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [PW-1:0] r_count;
  logic          w_push;
  logic          w_pop;

  // Handshakes depend only on registered occupancy, never on the partner's strobe.
  assign in_ready    = (r_count != PW'(DEPTH));
  assign out_valid   = (r_count != {PW{1'b0}});
  assign almost_full = (r_count >= PW'(AF_THRESH));
  assign count       = r_count;
  assign w_push      = in_valid & in_ready;
  assign w_pop       = out_valid & out_ready;

  // Pointer and occupancy state; reset outranks flush, both discard contents.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_wptr  <= {PW{1'b0}};
      r_rptr  <= {PW{1'b0}};
      r_count <= {PW{1'b0}};
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + PW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + PW'(1);
        2'b01:   r_count <= r_count - PW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  fifo_regfile #(
    .W     (W),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_regfile (
    .i_clk   (clk),
    .i_we    (w_push),
    .i_waddr (r_wptr[AW-1:0]),
    .i_wdata (in_data),
    .i_raddr (r_rptr[AW-1:0]),
    .o_rdata (out_data)
  );

endmodule

// File: tb/tb_fwft_fifo.sv
// Self-checking bench for fwft_fifo: directed vector table, hand-written corner
// sequences and randomized traffic checked against a queue-based reference model.
module tb_fwft_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       flush = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready = 1'b0;
  logic [2:0] count;
  logic       almost_full;

  int checks = 0;
  int failures = 0;
  logic [7:0] mq[$];

  always #5 clk = ~clk;

  fwft_fifo #(.W(8), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .count(count), .almost_full(almost_full)
  );

  typedef struct {
    logic       rst, flush, iv;
    logic [7:0] d;
    logic       ordy;
    logic [2:0] e_count;
    logic       e_ir, e_ov, e_af;
    logic [7:0] e_data;
    logic       data_dc;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Drive one cycle; compare pre-edge outputs with the model, then advance the model.
  task automatic step(input logic r, input logic f, input logic iv, input logic [7:0] d,
                      input logic ordy, input string tag);
    logic m_ir, m_ov, m_push, m_pop;
    rst = r; flush = f; in_valid = iv; in_data = d; out_ready = ordy;
    #1;
    m_ir = (mq.size() != 4);
    m_ov = (mq.size() != 0);
    chk({tag, ".count"}, 32'(count), 32'(mq.size()));
    chk({tag, ".in_ready"}, 32'(in_ready), 32'(m_ir));
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(m_ov));
    chk({tag, ".almost_full"}, 32'(almost_full), 32'(mq.size() >= 3));
    if (m_ov) chk({tag, ".out_data"}, 32'(out_data), 32'(mq[0]));
    m_push = iv && m_ir;
    m_pop  = m_ov && ordy;
    @(posedge clk);
    if (r || f) begin
      mq.delete();
    end else begin
      if (m_pop) void'(mq.pop_front());
      if (m_push) mq.push_back(d);
    end
    #1;
  endtask

  task automatic post(input string tag, input logic [2:0] c, input logic ir,
                      input logic ov, input logic af, input logic [7:0] d, input logic dc);
    chk({tag, ".count"}, 32'(count), 32'(c));
    chk({tag, ".in_ready"}, 32'(in_ready), 32'(ir));
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(ov));
    chk({tag, ".almost_full"}, 32'(almost_full), 32'(af));
    if (!dc) chk({tag, ".out_data"}, 32'(out_data), 32'(d));
  endtask

  vec_t tbl[$];

  initial begin
    // Expected values are after the edge on which the vector is applied.
    //             rst   flsh  iv    data   ordy  cnt   ir    ov    af    exp    dc
    tbl.push_back('{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 8'h11, 1'b0, 3'd1, 1'b1, 1'b1, 1'b0, 8'h11, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 8'h22, 1'b0, 3'd2, 1'b1, 1'b1, 1'b0, 8'h11, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 8'h33, 1'b0, 3'd3, 1'b1, 1'b1, 1'b1, 8'h11, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 8'h44, 1'b0, 3'd4, 1'b0, 1'b1, 1'b1, 8'h11, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 8'h66, 1'b0, 3'd4, 1'b0, 1'b1, 1'b1, 8'h11, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 3'd3, 1'b1, 1'b1, 1'b1, 8'h22, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 3'd2, 1'b1, 1'b1, 1'b0, 8'h33, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 3'd1, 1'b1, 1'b1, 1'b0, 8'h44, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 3'd0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 8'h11, 1'b0, 3'd1, 1'b1, 1'b1, 1'b0, 8'h11, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 8'h22, 1'b0, 3'd2, 1'b1, 1'b1, 1'b0, 8'h11, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 8'h33, 1'b0, 3'd3, 1'b1, 1'b1, 1'b1, 8'h11, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 8'h44, 1'b0, 3'd4, 1'b0, 1'b1, 1'b1, 8'h11, 1'b0});
    // Full with simultaneous offer and pop: 0x55 refused, count drops to 3.
    tbl.push_back('{1'b0, 1'b0, 1'b1, 8'h55, 1'b1, 3'd3, 1'b1, 1'b1, 1'b1, 8'h22, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 3'd2, 1'b1, 1'b1, 1'b0, 8'h33, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 8'h77, 1'b1, 3'd2, 1'b1, 1'b1, 1'b0, 8'h44, 1'b0});

    @(posedge clk); #1;
    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].rst, tbl[i].flush, tbl[i].iv, tbl[i].d, tbl[i].ordy, $sformatf("vec%0d.pre", i));
      post($sformatf("vec%0d", i), tbl[i].e_count, tbl[i].e_ir, tbl[i].e_ov,
           tbl[i].e_af, tbl[i].e_data, tbl[i].data_dc);
    end

    // Wrap: steady push+pop at count=2 with incrementing data.
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0, 1'b1, 8'(8'h80 + i), 1'b1, $sformatf("wrap%0d", i));
      chk($sformatf("wrap%0d.count_post", i), 32'(count), 32'd2);
    end
    chk("wrap.head", 32'(out_data), 32'h88);

    // Flush at count=3 with a concurrent offer: word dropped.
    step(1'b0, 1'b0, 1'b1, 8'h90, 1'b0, "fl.fill");
    post("fl.at3", 3'd3, 1'b1, 1'b1, 1'b1, 8'h88, 1'b0);
    step(1'b0, 1'b1, 1'b1, 8'h99, 1'b1, "fl.flush");
    post("fl.after", 3'd0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, "fl.idle");
    post("fl.idle_post", 3'd0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1);

    // Reset mid-stream at count=2, then a fresh push appears one cycle later.
    step(1'b0, 1'b0, 1'b1, 8'h31, 1'b0, "rs.p0");
    step(1'b0, 1'b0, 1'b1, 8'h32, 1'b0, "rs.p1");
    post("rs.at2", 3'd2, 1'b1, 1'b1, 1'b0, 8'h31, 1'b0);
    step(1'b1, 1'b1, 1'b1, 8'h33, 1'b1, "rs.rst");
    post("rs.after", 3'd0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
    step(1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, "rs.push");
    post("rs.a5", 3'd1, 1'b1, 1'b1, 1'b0, 8'hA5, 1'b0);

    // Randomized traffic against the queue model.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 99) < 2) ? 1'b1 : 1'b0,
           ($urandom_range(0, 99) < 3) ? 1'b1 : 1'b0,
           1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
           $sformatf("rnd%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
